grf_scoreboard: RTL and testbench

- Write-side bookkeeping for the 32x32 general register file in the 5-stage MIPS pipeline.
- Tracks every in-flight register write, from decode issue until writeback into the register file.
- Tells decode whether a source operand's producer is too far away (Tnew > Tuse); if so, it asserts stall.
- Sits beside the decode stage. Its writeback inputs are the same WE/A3 strobes that drive the register file.

---
 rtl/grf_scoreboard.sv | 121 ++++++++++++
 tb/tb_grf_scoreboard.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - GRF in-flight write scoreboard and Tnew/Tuse stall unit (optional SB_ERR_CHECK_EN)
module grf_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter int TNEW_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [4:0]        issue_rd,
    input  logic [TNEW_W-1:0] issue_tnew,
    input  logic [4:0]        rs_addr,
    input  logic [TNEW_W-1:0] rs_tuse,
    input  logic [4:0]        rt_addr,
    input  logic [TNEW_W-1:0] rt_tuse,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    output logic              stall,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [6:0]        inflight_total,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

    // Entry 0 is kept at zero so $zero never looks busy.
    logic [CNT_W-1:0]  r_cnt  [0:31];
    logic [TNEW_W-1:0] r_tnew [0:31];
    logic [6:0]        r_total;

    logic              w_iss;
    logic              w_wb;
    logic [CNT_W-1:0]  w_rs_cnt;
    logic [CNT_W-1:0]  w_rt_cnt;
    logic [TNEW_W-1:0] w_rs_tnew;
    logic [TNEW_W-1:0] w_rt_tnew;
    logic [6:0]        w_sum;

    assign w_rs_cnt  = r_cnt[rs_addr];
    assign w_rt_cnt  = r_cnt[rt_addr];
    assign w_rs_tnew = r_tnew[rs_addr];
    assign w_rt_tnew = r_tnew[rt_addr];

    // Busy/stall decode; a write landing this cycle that retires the last
    // outstanding write is seen through the register file's bypass.
    always_comb begin
        rs_busy = (rs_addr != 5'd0) && (w_rs_cnt != '0) &&
                  !(wb_we && (wb_addr == rs_addr) && (w_rs_cnt == CNT_W'(1)));
        rt_busy = (rt_addr != 5'd0) && (w_rt_cnt != '0) &&
                  !(wb_we && (wb_addr == rt_addr) && (w_rt_cnt == CNT_W'(1)));
        stall   = (rs_busy && (w_rs_tnew > rs_tuse)) ||
                  (rt_busy && (w_rt_tnew > rt_tuse));
    end

    assign w_iss = issue_valid && !stall && (issue_rd != 5'd0);
    assign w_wb  = wb_we && (wb_addr != 5'd0);

    // Per-register counter and youngest-Tnew update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r]  <= '0;
                r_tnew[r] <= '0;
            end
        end else begin
            r_cnt[0]  <= '0;
            r_tnew[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (w_iss && (issue_rd == 5'(r)) && w_wb && (wb_addr == 5'(r))) begin
                    r_tnew[r] <= issue_tnew;
                end else if (w_iss && (issue_rd == 5'(r))) begin
                    if (r_cnt[r] != CNT_MAX)
                        r_cnt[r] <= r_cnt[r] + CNT_W'(1);
                    r_tnew[r] <= issue_tnew;
                end else if (w_wb && (wb_addr == 5'(r)) && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
                    if (r_cnt[r] == CNT_W'(1))
                        r_tnew[r] <= '0;
                    else if (r_tnew[r] != '0)
                        r_tnew[r] <= r_tnew[r] - TNEW_W'(1);
                end else if (r_tnew[r] != '0) begin
                    r_tnew[r] <= r_tnew[r] - TNEW_W'(1);
                end
            end
        end
    end

    // Sum of all counters as currently held.
    always_comb begin
        w_sum = 7'd0;
        for (int r = 1; r < 32; r++)
            w_sum = w_sum + 7'(r_cnt[r]);
    end

    // Registered total, one cycle behind the counters.
    always_ff @(posedge clk) begin
        if (reset) r_total <= 7'd0;
        else       r_total <= w_sum;
    end

    assign inflight_total = r_total;

`ifdef SB_ERR_CHECK_EN
    logic r_err;

    // Sticky protocol error: overflowing issue or underflowing writeback.
    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if ((w_iss && (r_cnt[issue_rd] == CNT_MAX)) ||
                 (w_wb && (r_cnt[wb_addr] == '0)))
            r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - randomized self-checking bench for grf_scoreboard
module tb_grf_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [1:0] issue_tnew;
    logic [4:0] rs_addr;
    logic [1:0] rs_tuse;
    logic [4:0] rt_addr;
    logic [1:0] rt_tuse;
    logic       wb_we;
    logic [4:0] wb_addr;
    logic       stall;
    logic       rs_busy;
    logic       rt_busy;
    logic [6:0] inflight_total;
    logic       err;

    int checks = 0;
    int errors = 0;

    int m_cnt  [32];
    int m_tnew [32];
    int m_total;
    int m_err;
    logic e_stall, e_rs_busy, e_rt_busy;

    grf_scoreboard #(.MAX_INFLIGHT(3), .CNT_W(2), .TNEW_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tnew(issue_tnew),
        .rs_addr(rs_addr), .rs_tuse(rs_tuse), .rt_addr(rt_addr), .rt_tuse(rt_tuse),
        .wb_we(wb_we), .wb_addr(wb_addr),
        .stall(stall), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .inflight_total(inflight_total), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic m_busy(input int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (wb_we && int'(wb_addr) == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_eval();
        e_rs_busy = m_busy(int'(rs_addr));
        e_rt_busy = m_busy(int'(rt_addr));
        e_stall   = (e_rs_busy && m_tnew[rs_addr] > int'(rs_tuse)) ||
                    (e_rt_busy && m_tnew[rt_addr] > int'(rt_tuse));
    endtask

    task automatic model_edge();
        int  sum;
        bit  iss, wbk;
        model_eval();
        if (reset) begin
            foreach (m_cnt[r]) begin m_cnt[r] = 0; m_tnew[r] = 0; end
            m_total = 0;
            m_err   = 0;
            return;
        end
        sum = 0;
        for (int r = 1; r < 32; r++) sum += m_cnt[r];
        iss = issue_valid && !e_stall && issue_rd != 0;
        wbk = wb_we && wb_addr != 0;
`ifdef SB_ERR_CHECK_EN
        if ((iss && m_cnt[issue_rd] == 3) || (wbk && m_cnt[wb_addr] == 0)) m_err = 1;
`endif
        for (int r = 1; r < 32; r++) begin
            bit hi = iss && int'(issue_rd) == r;
            bit hw = wbk && int'(wb_addr) == r;
            int nt = (m_tnew[r] > 0) ? m_tnew[r] - 1 : 0;
            if (hi && hw) begin
                m_tnew[r] = int'(issue_tnew);
            end else if (hi) begin
                if (m_cnt[r] < 3) m_cnt[r]++;
                m_tnew[r] = int'(issue_tnew);
            end else if (hw && m_cnt[r] > 0) begin
                m_cnt[r]--;
                m_tnew[r] = (m_cnt[r] == 0) ? 0 : nt;
            end else begin
                m_tnew[r] = nt;
            end
        end
        m_total = sum;
    endtask

    task automatic drive(input bit iv, input int rd, input int tn,
                         input int rsa, input int rsu, input int rta, input int rtu,
                         input bit we, input int wa);
        issue_valid = iv;       issue_rd = 5'(rd);  issue_tnew = 2'(tn);
        rs_addr = 5'(rsa);      rs_tuse = 2'(rsu);
        rt_addr = 5'(rta);      rt_tuse = 2'(rtu);
        wb_we = we;             wb_addr = 5'(wa);
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 7, 3, 0, 0, 0, 0, 1, 7);
        advance();
        advance();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL reset_total got %0d exp 0", inflight_total); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        advance();
    endtask

    task automatic test_basic_stall();
        logic exp_s [3] = '{1'b1, 1'b1, 1'b0};
        drive(1, 5, 2, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
            checks++; if (stall !== exp_s[i]) begin errors++; $display("FAIL basic_stall[%0d] got %0b exp %0b", i, stall, exp_s[i]); end
            checks++; if (rs_busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %0b exp 1", i, rs_busy); end
            advance();
        end
        drive(0, 0, 0, 5, 0, 0, 0, 1, 5);
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL basic_wb_bypass got %0b exp 0", rs_busy); end
        advance();
        drive(0, 0, 0, 5, 0, 0, 0, 0, 0);
        advance();
        checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL basic_total got %0d exp 0", inflight_total); end
    endtask

    task automatic test_rd_zero();
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
        checks++; if (rs_busy !== 1'b0) begin errors++; $display("FAIL rd0_busy got %0b exp 0", rs_busy); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        checks++; if (inflight_total !== 7'd0) begin errors++; $display("FAIL rd0_total got %0d exp 0", inflight_total); end
    endtask

    task automatic test_double_issue();
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0); advance();
        drive(1, 8, 3, 0, 0, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 0, 0, 8, 1, 1, 8);
        checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL dbl_busy got %0b exp 1", rt_busy); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dbl_stall got %0b exp 1", stall); end
        checks++; if (inflight_total !== 7'd1) begin errors++; $display("FAIL dbl_total got %0d exp 1", inflight_total); end
        advance();
        drive(0, 0, 0, 0, 0, 8, 0, 0, 0);
        checks++; if (rt_busy !== 1'b1) begin errors++; $display("FAIL dbl_busy2 got %0b exp 1", rt_busy); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL dbl_stall2 got %0b exp 1", stall); end
        checks++; if (inflight_total !== 7'd2) begin errors++; $display("FAIL dbl_total2 got %0d exp 2", inflight_total); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 8); advance();
        drive(0, 0, 0, 0, 0, 8, 0, 0, 0);
        checks++; if (rt_busy !== 1'b0) begin errors++; $display("FAIL dbl_idle got %0b exp 0", rt_busy); end
        advance();
    endtask

    task automatic test_bypass_and_collide();
        drive(1, 9, 0, 0, 0, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 9, 0, 0, 0, 1, 9);
        checks++; if (rs_busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL bypass got busy=%0b stall=%0b exp 0 0", rs_busy, stall); end
        advance();
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0); advance();
        drive(1, 12, 2, 0, 0, 0, 0, 1, 12); advance();
        drive(0, 0, 0, 12, 1, 0, 0, 0, 0);
        checks++; if (rs_busy !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL collide got busy=%0b stall=%0b exp 1 1", rs_busy, stall); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 12); advance();
    endtask

    task automatic test_err_and_reset();
`ifdef SB_ERR_CHECK_EN
        drive(0, 0, 0, 0, 0, 0, 0, 1, 20); advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky[%0d] got %0b exp 1", i, err); end
            advance();
        end
`endif
        drive(1, 3, 3, 0, 0, 0, 0, 0, 0); advance();
        drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL midstall_pre got %0b exp 1", stall); end
        reset = 1'b1;
        advance();
        reset = 1'b0;
        drive(0, 0, 0, 3, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0 || rs_busy !== 1'b0) begin errors++; $display("FAIL midstall_reset got stall=%0b busy=%0b exp 0 0", stall, rs_busy); end
        checks++; if (inflight_total !== 7'd0 || err !== 1'b0) begin errors++; $display("FAIL midstall_state got total=%0d err=%0b exp 0 0", inflight_total, err); end
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(99) < 2);
            drive($urandom_range(1), $urandom_range(4), $urandom_range(3),
                  $urandom_range(4), $urandom_range(3), $urandom_range(4), $urandom_range(3),
                  ($urandom_range(9) < 4), $urandom_range(4));
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall@%0d got %0b exp %0b", n, stall, e_stall); end
            checks++; if (rs_busy !== e_rs_busy) begin errors++; $display("FAIL rnd_rs_busy@%0d got %0b exp %0b", n, rs_busy, e_rs_busy); end
            checks++; if (rt_busy !== e_rt_busy) begin errors++; $display("FAIL rnd_rt_busy@%0d got %0b exp %0b", n, rt_busy, e_rt_busy); end
            checks++; if (int'(inflight_total) !== m_total) begin errors++; $display("FAIL rnd_total@%0d got %0d exp %0d", n, inflight_total, m_total); end
            checks++; if (int'(err) !== m_err) begin errors++; $display("FAIL rnd_err@%0d got %0b exp %0d", n, err, m_err); end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        foreach (m_cnt[r]) begin m_cnt[r] = 0; m_tnew[r] = 0; end
        m_total = 0;
        m_err   = 0;
        test_reset();
        test_basic_stall();
        test_rd_zero();
        test_double_issue();
        test_bypass_and_collide();
        test_err_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
